// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear/preset sequencer for four cascaded BCD digit counters (MM:SS).
// Front-panel pulses are registered once; every output is a register updated from those registered events.
module stopwatch_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       preset,
  input  logic       dir,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] count,
  output logic       mode,
  output logic       load,
  output logic       cnt_rst,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_PAUSE   = 2'b10,
    S_EXPIRED = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic tick_q, ss_q, clr_q, pre_q, dir_q;

  logic [3:0] count_d;
  logic       mode_d, load_d, cnt_rst_d, alarm_d;

  logic       all_zero, up_terminal;
  logic       roll0, roll1, roll2;
  logic [3:0] count_vec;
  logic       down_expired;
  logic       tick_ok;
  logic       can_start;

  // Event capture stage: an event seen at edge N acts on STATE at edge N+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= 1'b0;
      ss_q   <= 1'b0;
      clr_q  <= 1'b0;
      pre_q  <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      tick_q <= tick;
      ss_q   <= start_stop;
      clr_q  <= clear;
      pre_q  <= preset;
      dir_q  <= dir;
    end
  end

  assign all_zero    = (d0 == 4'd0) && (d1 == 4'd0) && (d2 == 4'd0) && (d3 == 4'd0);
  assign up_terminal = (d3 == 4'd5) && (d2 == 4'd9) && (d1 == 4'd5) && (d0 == 4'd9);

  // Rollover digit depends on direction: 9/5/9 counting up, 0 counting down.
  assign roll0 = mode ? (d0 == 4'd9) : (d0 == 4'd0);
  assign roll1 = mode ? (d1 == 4'd5) : (d1 == 4'd0);
  assign roll2 = mode ? (d2 == 4'd9) : (d2 == 4'd0);
  assign count_vec = {roll0 & roll1 & roll2, roll0 & roll1, roll0, 1'b1};

  // Gating on count==0 ignores digits that are stale while a COUNT cycle is in flight.
  assign down_expired = !mode && all_zero && (count == 4'd0);
  assign tick_ok      = tick_q && !pre_q;
  assign can_start    = (state_q == S_IDLE) || (state_q == S_PAUSE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count   <= 4'd0;
      mode    <= 1'b1;
      load    <= 1'b0;
      cnt_rst <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      mode    <= mode_d;
      load    <= load_d;
      cnt_rst <= cnt_rst_d;
      alarm   <= alarm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_q) begin
      state_d = S_IDLE;
    end else if (ss_q) begin
      case (state_q)
        S_IDLE, S_PAUSE: state_d = (!dir_q && all_zero) ? S_EXPIRED : S_RUN;
        S_RUN:           state_d = S_PAUSE;
        S_EXPIRED:       state_d = S_PAUSE;
        default:         state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pre_q) state_d = S_PAUSE;
        end
        S_RUN: begin
          if (down_expired) begin
            state_d = S_EXPIRED;
          end else if (tick_ok && mode && up_terminal) begin
            state_d = S_EXPIRED;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    count_d   = 4'd0;
    mode_d    = mode;
    load_d    = 1'b0;
    cnt_rst_d = 1'b0;
    if (clr_q) begin
      cnt_rst_d = 1'b1;
    end else if (ss_q) begin
      // Direction is latched only on a real entry into RUN, so MODE is frozen while running.
      if (can_start && (state_d == S_RUN)) mode_d = dir_q;
    end else if (pre_q) begin
      load_d = can_start;
    end else if (tick_ok && (state_q == S_RUN) && (state_d == S_RUN)) begin
      count_d = count_vec;
    end
    alarm_d = (state_d == S_EXPIRED);
  end

  assign state = state_q;

endmodule
